// File: rtl/rv32_isa_pkg.sv
// rtl/rv32_isa_pkg.sv - RV32I opcodes, funct fields, instruction ids and id lookup
package rv32_isa_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [5:0] ID_BEQ   = 6'd0;
    localparam logic [5:0] ID_BGE   = 6'd1;
    localparam logic [5:0] ID_BGEU  = 6'd2;
    localparam logic [5:0] ID_BLT   = 6'd3;
    localparam logic [5:0] ID_BLTU  = 6'd4;
    localparam logic [5:0] ID_BNE   = 6'd5;
    localparam logic [5:0] ID_LUI   = 6'd6;
    localparam logic [5:0] ID_AUIPC = 6'd7;
    localparam logic [5:0] ID_JAL   = 6'd8;
    localparam logic [5:0] ID_JALR  = 6'd9;
    localparam logic [5:0] ID_LB    = 6'd10;
    localparam logic [5:0] ID_LH    = 6'd11;
    localparam logic [5:0] ID_LW    = 6'd12;
    localparam logic [5:0] ID_LBU   = 6'd13;
    localparam logic [5:0] ID_LHU   = 6'd14;
    localparam logic [5:0] ID_SB    = 6'd15;
    localparam logic [5:0] ID_SH    = 6'd16;
    localparam logic [5:0] ID_SW    = 6'd17;
    localparam logic [5:0] ID_ADDI  = 6'd18;
    localparam logic [5:0] ID_SLTI  = 6'd19;
    localparam logic [5:0] ID_SLTIU = 6'd20;
    localparam logic [5:0] ID_XORI  = 6'd21;
    localparam logic [5:0] ID_ORI   = 6'd22;
    localparam logic [5:0] ID_ANDI  = 6'd23;
    localparam logic [5:0] ID_SLLI  = 6'd24;
    localparam logic [5:0] ID_SRLI  = 6'd25;
    localparam logic [5:0] ID_SRAI  = 6'd26;
    localparam logic [5:0] ID_ADD   = 6'd27;
    localparam logic [5:0] ID_SUB   = 6'd28;
    localparam logic [5:0] ID_SLL   = 6'd29;
    localparam logic [5:0] ID_SLT   = 6'd30;
    localparam logic [5:0] ID_SLTU  = 6'd31;
    localparam logic [5:0] ID_XOR   = 6'd32;
    localparam logic [5:0] ID_SRL   = 6'd33;
    localparam logic [5:0] ID_SRA   = 6'd34;
    localparam logic [5:0] ID_OR    = 6'd35;
    localparam logic [5:0] ID_AND   = 6'd36;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_I_SHIFT,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    typedef struct packed {
        logic       valid;
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } inst_info_t;

    function automatic inst_info_t mk_info(input fmt_e fmt, input logic [6:0] opcode,
                                           input logic [2:0] funct3, input logic [6:0] funct7);
        inst_info_t info;
        info.valid  = 1'b1;
        info.fmt    = fmt;
        info.opcode = opcode;
        info.funct3 = funct3;
        info.funct7 = funct7;
        return info;
    endfunction

    // Maps an instruction id to its format and fixed encoding fields; ids past AND are invalid.
    function automatic inst_info_t id_lookup(input logic [5:0] id);
        inst_info_t info;
        info = mk_info(FMT_R, OPC_OP, F3_ADD, F7_BASE);
        case (id)
            ID_BEQ:   info = mk_info(FMT_B, OPC_BRANCH, F3_BEQ, F7_BASE);
            ID_BGE:   info = mk_info(FMT_B, OPC_BRANCH, F3_BGE, F7_BASE);
            ID_BGEU:  info = mk_info(FMT_B, OPC_BRANCH, F3_BGEU, F7_BASE);
            ID_BLT:   info = mk_info(FMT_B, OPC_BRANCH, F3_BLT, F7_BASE);
            ID_BLTU:  info = mk_info(FMT_B, OPC_BRANCH, F3_BLTU, F7_BASE);
            ID_BNE:   info = mk_info(FMT_B, OPC_BRANCH, F3_BNE, F7_BASE);
            ID_LUI:   info = mk_info(FMT_U, OPC_LUI, 3'b000, F7_BASE);
            ID_AUIPC: info = mk_info(FMT_U, OPC_AUIPC, 3'b000, F7_BASE);
            ID_JAL:   info = mk_info(FMT_J, OPC_JAL, 3'b000, F7_BASE);
            ID_JALR:  info = mk_info(FMT_I, OPC_JALR, 3'b000, F7_BASE);
            ID_LB:    info = mk_info(FMT_I, OPC_LOAD, F3_B, F7_BASE);
            ID_LH:    info = mk_info(FMT_I, OPC_LOAD, F3_H, F7_BASE);
            ID_LW:    info = mk_info(FMT_I, OPC_LOAD, F3_W, F7_BASE);
            ID_LBU:   info = mk_info(FMT_I, OPC_LOAD, F3_BU, F7_BASE);
            ID_LHU:   info = mk_info(FMT_I, OPC_LOAD, F3_HU, F7_BASE);
            ID_SB:    info = mk_info(FMT_S, OPC_STORE, F3_B, F7_BASE);
            ID_SH:    info = mk_info(FMT_S, OPC_STORE, F3_H, F7_BASE);
            ID_SW:    info = mk_info(FMT_S, OPC_STORE, F3_W, F7_BASE);
            ID_ADDI:  info = mk_info(FMT_I, OPC_OP_IMM, F3_ADD, F7_BASE);
            ID_SLTI:  info = mk_info(FMT_I, OPC_OP_IMM, F3_SLT, F7_BASE);
            ID_SLTIU: info = mk_info(FMT_I, OPC_OP_IMM, F3_SLTU, F7_BASE);
            ID_XORI:  info = mk_info(FMT_I, OPC_OP_IMM, F3_XOR, F7_BASE);
            ID_ORI:   info = mk_info(FMT_I, OPC_OP_IMM, F3_OR, F7_BASE);
            ID_ANDI:  info = mk_info(FMT_I, OPC_OP_IMM, F3_AND, F7_BASE);
            ID_SLLI:  info = mk_info(FMT_I_SHIFT, OPC_OP_IMM, F3_SLL, F7_BASE);
            ID_SRLI:  info = mk_info(FMT_I_SHIFT, OPC_OP_IMM, F3_SR, F7_BASE);
            ID_SRAI:  info = mk_info(FMT_I_SHIFT, OPC_OP_IMM, F3_SR, F7_ALT);
            ID_ADD:   info = mk_info(FMT_R, OPC_OP, F3_ADD, F7_BASE);
            ID_SUB:   info = mk_info(FMT_R, OPC_OP, F3_ADD, F7_ALT);
            ID_SLL:   info = mk_info(FMT_R, OPC_OP, F3_SLL, F7_BASE);
            ID_SLT:   info = mk_info(FMT_R, OPC_OP, F3_SLT, F7_BASE);
            ID_SLTU:  info = mk_info(FMT_R, OPC_OP, F3_SLTU, F7_BASE);
            ID_XOR:   info = mk_info(FMT_R, OPC_OP, F3_XOR, F7_BASE);
            ID_SRL:   info = mk_info(FMT_R, OPC_OP, F3_SR, F7_BASE);
            ID_SRA:   info = mk_info(FMT_R, OPC_OP, F3_SR, F7_ALT);
            ID_OR:    info = mk_info(FMT_R, OPC_OP, F3_OR, F7_BASE);
            ID_AND:   info = mk_info(FMT_R, OPC_OP, F3_AND, F7_BASE);
            default:  info.valid = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/rv32_imm_packer.sv
// rtl/rv32_imm_packer.sv - assembles an RV32I word from format, fields and immediate
module rv32_imm_packer
    import rv32_isa_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        ok
);

    // Range checks: the immediate must be the sign extension of its top encodable bit.
    logic fits_12;
    logic fits_13_even;
    logic fits_21_even;
    assign fits_12      = (imm[31:11] == {21{imm[11]}});
    assign fits_13_even = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign fits_21_even = (imm[31:20] == {12{imm[20]}}) && !imm[0];

    // Field placement per format; fields a format does not use stay zero.
    always_comb begin
        word = 32'h0000_0000;
        ok   = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
                ok   = 1'b1;
            end
            FMT_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                ok   = fits_12;
            end
            FMT_I_SHIFT: begin
                word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                ok   = (imm[31:5] == 27'd0);
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                ok   = fits_12;
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                ok   = fits_13_even;
            end
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                ok   = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                ok   = fits_21_even;
            end
            default: begin
                word = 32'h0000_0000;
                ok   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rv32_instruction_encoder.sv
// rtl/rv32_instruction_encoder.sv - two-stage RV32I encoder emitting words with sequential imem addresses
module rv32_instruction_encoder
    import rv32_isa_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        inst_id,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction_code,
    output logic [ADDR_W-1:0] out_addr,
    output logic              invalid_request,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(BASE_ADDR + 4 * (DEPTH - 1));

    logic        s1_valid;
    logic [5:0]  s1_id;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    inst_info_t  s1_info;
    logic [31:0] s1_word;
    logic        s1_fmt_ok;
    logic        s1_ok;

    logic        s2_adv;
    logic        s1_adv;
    logic        accept;

    assign s2_adv    = !out_valid || out_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign req_ready = !rst && en && (!s1_valid || s2_adv);
    assign accept    = req_valid && req_ready;

    assign s1_info = id_lookup(s1_id);
    assign s1_ok   = s1_info.valid && s1_fmt_ok;

    rv32_imm_packer u_packer (
        .fmt    (s1_info.fmt),
        .opcode (s1_info.opcode),
        .funct3 (s1_info.funct3),
        .funct7 (s1_info.funct7),
        .rd     (s1_rd),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .imm    (s1_imm),
        .word   (s1_word),
        .ok     (s1_fmt_ok)
    );

    // Request stage: capture the raw request; it leaves when the output stage can take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= 6'd0;
            s1_rd    <= 5'd0;
            s1_rs1   <= 5'd0;
            s1_rs2   <= 5'd0;
            s1_imm   <= 32'd0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_id    <= inst_id;
            s1_rd    <= rd;
            s1_rs1   <= rs1;
            s1_rs2   <= rs2;
            s1_imm   <= imm;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Output stage: only well-formed words load; invalid ones vanish and the slot drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            instruction_code <= 32'd0;
        end else if (s1_adv && s1_ok) begin
            out_valid        <= 1'b1;
            instruction_code <= s1_word;
        end else if (out_ready) begin
            out_valid        <= 1'b0;
        end
    end

    // Drop reporting: one-cycle pulse and a saturating counter of discarded requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_request <= 1'b0;
            err_count       <= '0;
        end else begin
            invalid_request <= s1_adv && !s1_ok;
            if (s1_adv && !s1_ok && (err_count != {ERR_W{1'b1}})) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

    // Write address: steps per delivered word and wraps after the last slot of the region.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_addr <= ADDR_FIRST;
        end else if (out_valid && out_ready) begin
            if (out_addr == ADDR_LAST) begin
                out_addr <= ADDR_FIRST;
            end else begin
                out_addr <= out_addr + ADDR_W'(4);
            end
        end
    end

endmodule
